// File: rtl/flash_bus_bridge.sv
// flash_bus_bridge
// Front-end between the 6809 bus and the SPI flash controller. Brings the E/Q
// phase clocks into the clk domain, decodes the 4 KB flash window, hands a
// single-cycle request to the controller and holds the CPU off with MRDY until
// the controller answers (or the transaction times out).

module flash_bus_bridge #(
    parameter logic [3:0] BASE_NIBBLE    = 4'hE,
    parameter int         TIMEOUT_CYCLES = 4095,
    parameter int         SYNC_STAGES    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_E,
    input  logic        i_Q,
    input  logic [15:0] i_ADDRESS_BUS,
    input  logic [7:0]  i_DataBus,
    input  logic        i_RW,
    output logic        o_MRDY,
    output logic [7:0]  o_DataBus,
    output logic        o_data_oe,
    output logic        o_req,
    output logic        o_rw,
    output logic [11:0] o_addr,
    output logic [7:0]  o_wdata,
    input  logic        i_done,
    input  logic [7:0]  i_rdata,
    output logic        o_timeout
);

    // last WAIT cycle is the one where the counter holds TIMEOUT_CYCLES-1,
    // giving exactly TIMEOUT_CYCLES cycles spent in WAIT before abort
    localparam logic [11:0] TO_LAST = 12'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WDATA   = 3'd1,
        S_REQ     = 3'd2,
        S_WAIT    = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [SYNC_STAGES-1:0] r_e_sync;
    logic [SYNC_STAGES-1:0] r_q_sync;
    logic                   r_e_d;
    logic                   r_q_d;
    logic [11:0]            r_cnt;

    logic w_sync_e;
    logic w_sync_q;
    logic w_q_rise;
    logic w_e_fall;
    logic w_hit;
    logic w_capture;
    logic w_expire;
    logic w_mrdy_nxt;
    logic w_oe_nxt;
    logic w_req_nxt;

    // E/Q synchronisers plus one delay flop each for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_e_sync <= '0;
            r_q_sync <= '0;
            r_e_d    <= 1'b0;
            r_q_d    <= 1'b0;
        end else begin
            r_e_sync <= {r_e_sync[SYNC_STAGES-2:0], i_E};
            r_q_sync <= {r_q_sync[SYNC_STAGES-2:0], i_Q};
            r_e_d    <= w_sync_e;
            r_q_d    <= w_sync_q;
        end
    end

    assign w_sync_e  = r_e_sync[SYNC_STAGES-1];
    assign w_sync_q  = r_q_sync[SYNC_STAGES-1];
    assign w_q_rise  = w_sync_q & ~r_q_d;
    assign w_e_fall  = ~w_sync_e & r_e_d;
    assign w_hit     = (i_ADDRESS_BUS[15:12] == BASE_NIBBLE);
    assign w_capture = (r_state == S_IDLE) && w_q_rise && w_hit;
    assign w_expire  = (r_cnt == TO_LAST);

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // next-state logic; q_rise outside IDLE and i_done outside WAIT fall through
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_capture) w_next = i_RW ? S_REQ : S_WDATA;
            S_WDATA:   if (w_sync_e) w_next = S_REQ;
            S_REQ:     w_next = S_WAIT;
            S_WAIT:    if (i_done || w_expire) w_next = S_RELEASE;
            S_RELEASE: if (w_e_fall) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // output decode from the upcoming state so every output is registered
    always_comb begin
        w_mrdy_nxt = 1'b1;
        w_oe_nxt   = 1'b0;
        w_req_nxt  = 1'b0;
        if (w_next == S_WDATA || w_next == S_REQ || w_next == S_WAIT)
            w_mrdy_nxt = 1'b0;
        // direction was latched at capture, long before RELEASE is entered
        if (w_next == S_RELEASE)
            w_oe_nxt = o_rw;
        // request follows the REQ state by one clock
        if (r_state == S_REQ)
            w_req_nxt = 1'b1;
    end

    // bus handshake output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_MRDY    <= 1'b1;
            o_data_oe <= 1'b0;
            o_req     <= 1'b0;
        end else begin
            o_MRDY    <= w_mrdy_nxt;
            o_data_oe <= w_oe_nxt;
            o_req     <= w_req_nxt;
        end
    end

    // request capture: address and direction at Q rise, write data once E is high
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_addr  <= 12'h000;
            o_rw    <= 1'b1;
            o_wdata <= 8'h00;
        end else begin
            if (w_capture) begin
                o_addr <= i_ADDRESS_BUS[11:0];
                o_rw   <= i_RW;
            end
            if (r_state == S_WDATA && w_sync_e)
                o_wdata <= i_DataBus;
        end
    end

    // WAIT cycle counter, cleared while the request goes out
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                 r_cnt <= 12'h000;
        else if (r_state == S_REQ)  r_cnt <= 12'h000;
        else if (r_state == S_WAIT) r_cnt <= r_cnt + 12'h001;
    end

    // completion: a done on the expiry cycle still wins over the abort
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_DataBus <= 8'h00;
            o_timeout <= 1'b0;
        end else if (r_state == S_WAIT) begin
            if (i_done) begin
                if (o_rw) o_DataBus <= i_rdata;
            end else if (w_expire) begin
                o_DataBus <= 8'hFF;
                o_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_flash_bus_bridge.sv
// tb_flash_bus_bridge
// Directed bus cycles against flash_bus_bridge with a simple SPI-side
// responder; expected values are hand-derived from the bus timing.

module tb_flash_bus_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_E = 1'b0;
    logic        i_Q = 1'b0;
    logic [15:0] i_ADDRESS_BUS = 16'h0000;
    logic [7:0]  i_DataBus = 8'h00;
    logic        i_RW = 1'b1;
    logic        o_MRDY;
    logic [7:0]  o_DataBus;
    logic        o_data_oe;
    logic        o_req;
    logic        o_rw;
    logic [11:0] o_addr;
    logic [7:0]  o_wdata;
    logic        i_done = 1'b0;
    logic [7:0]  i_rdata = 8'h00;
    logic        o_timeout;

    flash_bus_bridge dut (
        .clk(clk), .reset(reset), .i_E(i_E), .i_Q(i_Q),
        .i_ADDRESS_BUS(i_ADDRESS_BUS), .i_DataBus(i_DataBus), .i_RW(i_RW),
        .o_MRDY(o_MRDY), .o_DataBus(o_DataBus), .o_data_oe(o_data_oe),
        .o_req(o_req), .o_rw(o_rw), .o_addr(o_addr), .o_wdata(o_wdata),
        .i_done(i_done), .i_rdata(i_rdata), .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // monitor counters, written only by the monitor process
    int cyc = 0;
    int req_cnt = 0;
    int mrdy_lo = 0;
    int oe_cnt = 0;
    int last_req_cyc = 0;

    // responder controls, written only by the main process
    bit       resp_en = 1'b0;
    int       resp_delay = 10;
    logic [7:0] resp_data = 8'h00;

    // per-cycle results from bus_cycle
    int res_reqs, res_mrdy_lo, res_oe_cnt, res_lat_q, res_lat_e;
    int res_rd, res_oe_rel, res_oe_end, res_mrdy_end;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (o_req) begin
            req_cnt++;
            last_req_cyc = cyc;
        end
        if (!o_MRDY) mrdy_lo++;
        if (o_data_oe) oe_cnt++;
    end

    // SPI-side model: answer each request resp_delay cycles later
    always begin
        @(posedge clk);
        #1;
        if (o_req && resp_en) begin
            repeat (resp_delay) @(posedge clk);
            #1;
            i_done  = 1'b1;
            i_rdata = resp_data;
            @(posedge clk);
            #1;
            i_done  = 1'b0;
            i_rdata = 8'h00;
        end
    end

    // one 6809 cycle: Q rises, E rises 6 clocks later, wait for MRDY,
    // then Q falls and E falls; optional extra Q pulse during the stretch
    task automatic bus_cycle(input logic [15:0] a, input logic rw, input logic [7:0] wd,
                             input bit inject);
        int r0, m0, o0, c_q, c_e, n;
        @(negedge clk);
        i_ADDRESS_BUS = a;
        i_RW = rw;
        i_DataBus = wd;
        r0 = req_cnt; m0 = mrdy_lo; o0 = oe_cnt;
        i_Q = 1'b1;
        c_q = cyc;
        repeat (6) @(negedge clk);
        i_E = 1'b1;
        c_e = cyc;
        if (inject) begin
            repeat (20) @(negedge clk);
            i_Q = 1'b0;
            repeat (4) @(negedge clk);
            i_Q = 1'b1;
        end
        n = 0;
        while (!o_MRDY && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!o_MRDY) chk("mrdy_wait_bound", 32'(o_MRDY), 32'd1);
        repeat (3) @(negedge clk);
        res_rd = int'(o_DataBus);
        res_oe_rel = int'(o_data_oe);
        i_Q = 1'b0;
        repeat (3) @(negedge clk);
        i_E = 1'b0;
        repeat (6) @(negedge clk);
        res_oe_end = int'(o_data_oe);
        res_mrdy_end = int'(o_MRDY);
        res_reqs = req_cnt - r0;
        res_mrdy_lo = mrdy_lo - m0;
        res_oe_cnt = oe_cnt - o0;
        res_lat_q = last_req_cyc - c_q;
        res_lat_e = last_req_cyc - c_e;
    endtask

    initial begin
        int r_b2b;
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_mrdy", 32'(o_MRDY), 32'd1);
        chk("rst_oe", 32'(o_data_oe), 32'd0);
        chk("rst_req", 32'(o_req), 32'd0);
        chk("rst_rw", 32'(o_rw), 32'd1);
        chk("rst_addr", 32'(o_addr), 32'h0);
        chk("rst_wdata", 32'(o_wdata), 32'h0);
        chk("rst_dbus", 32'(o_DataBus), 32'h0);
        chk("rst_tout", 32'(o_timeout), 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // read hit
        resp_en = 1'b1; resp_delay = 50; resp_data = 8'hA5;
        bus_cycle(16'hE123, 1'b1, 8'h00, 1'b0);
        chk("rd_reqs", 32'(res_reqs), 32'd1);
        chk("rd_addr", 32'(o_addr), 32'h123);
        chk("rd_rw", 32'(o_rw), 32'd1);
        chk("rd_lat", 32'(res_lat_q), 32'd4);
        chk("rd_mrdy_lo", 32'(res_mrdy_lo), 32'd52);
        chk("rd_data", 32'(res_rd), 32'hA5);
        chk("rd_oe_rel", 32'(res_oe_rel), 32'd1);
        chk("rd_oe_end", 32'(res_oe_end), 32'd0);
        chk("rd_mrdy_end", 32'(res_mrdy_end), 32'd1);

        // write hit
        resp_delay = 20; resp_data = 8'h77;
        bus_cycle(16'hE7FF, 1'b0, 8'h3C, 1'b0);
        chk("wr_reqs", 32'(res_reqs), 32'd1);
        chk("wr_lat_e", 32'(res_lat_e), 32'd4);
        chk("wr_addr", 32'(o_addr), 32'h7FF);
        chk("wr_rw", 32'(o_rw), 32'd0);
        chk("wr_wdata", 32'(o_wdata), 32'h3C);
        chk("wr_oe_cnt", 32'(res_oe_cnt), 32'd0);
        chk("wr_mrdy_lo", 32'(res_mrdy_lo), 32'd28);
        chk("wr_dbus_hold", 32'(o_DataBus), 32'hA5);
        chk("wr_mrdy_end", 32'(res_mrdy_end), 32'd1);

        // miss
        bus_cycle(16'hD000, 1'b1, 8'h00, 1'b0);
        chk("miss_reqs", 32'(res_reqs), 32'd0);
        chk("miss_mrdy_lo", 32'(res_mrdy_lo), 32'd0);
        chk("miss_oe", 32'(res_oe_cnt), 32'd0);

        // timeout
        resp_en = 1'b0;
        bus_cycle(16'hE200, 1'b1, 8'h00, 1'b0);
        chk("to_reqs", 32'(res_reqs), 32'd1);
        chk("to_mrdy_lo", 32'(res_mrdy_lo), 32'd4096);
        chk("to_dbus", 32'(res_rd), 32'hFF);
        chk("to_flag", 32'(o_timeout), 32'd1);
        chk("to_oe_rel", 32'(res_oe_rel), 32'd1);
        chk("to_mrdy_end", 32'(res_mrdy_end), 32'd1);

        // reset during WAIT
        @(negedge clk);
        i_ADDRESS_BUS = 16'hE400; i_RW = 1'b1; i_Q = 1'b1;
        repeat (6) @(negedge clk);
        i_E = 1'b1;
        repeat (10) @(negedge clk);
        chk("mid_mrdy_pre", 32'(o_MRDY), 32'd0);
        reset = 1'b0;
        #1;
        chk("mid_mrdy", 32'(o_MRDY), 32'd1);
        chk("mid_oe", 32'(o_data_oe), 32'd0);
        chk("mid_tout", 32'(o_timeout), 32'd0);
        chk("mid_dbus", 32'(o_DataBus), 32'h0);
        i_Q = 1'b0; i_E = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        resp_en = 1'b1; resp_delay = 10; resp_data = 8'h5A;
        bus_cycle(16'hE010, 1'b1, 8'h00, 1'b0);
        chk("post_reqs", 32'(res_reqs), 32'd1);
        chk("post_addr", 32'(o_addr), 32'h010);
        chk("post_data", 32'(res_rd), 32'h5A);
        chk("post_oe_rel", 32'(res_oe_rel), 32'd1);

        // back-to-back with an extra Q pulse during the first stretch
        resp_delay = 50; resp_data = 8'hC3;
        bus_cycle(16'hE055, 1'b1, 8'h00, 1'b1);
        r_b2b = res_reqs;
        chk("b2b1_data", 32'(res_rd), 32'hC3);
        resp_delay = 5; resp_data = 8'h96;
        bus_cycle(16'hE056, 1'b1, 8'h00, 1'b0);
        r_b2b += res_reqs;
        chk("b2b_reqs", 32'(r_b2b), 32'd2);
        chk("b2b2_data", 32'(res_rd), 32'h96);
        chk("b2b2_addr", 32'(o_addr), 32'h056);
        chk("b2b_tout", 32'(o_timeout), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
